// File: rtl/decode_pkg.sv
// Shared constants and types for the decode prefix sequencer: prefix byte codes,
// segment/rep encodings, the sequencer state type and the instruction length limit.
package decode_pkg;

    localparam logic [7:0] PFX_LOCK   = 8'hF0;
    localparam logic [7:0] PFX_REPNE  = 8'hF2;
    localparam logic [7:0] PFX_REP    = 8'hF3;
    localparam logic [7:0] PFX_ES     = 8'h26;
    localparam logic [7:0] PFX_CS     = 8'h2E;
    localparam logic [7:0] PFX_SS     = 8'h36;
    localparam logic [7:0] PFX_DS     = 8'h3E;
    localparam logic [7:0] PFX_FS     = 8'h64;
    localparam logic [7:0] PFX_GS     = 8'h65;
    localparam logic [7:0] PFX_OPSIZE = 8'h66;
    localparam logic [7:0] PFX_ADSIZE = 8'h67;
    localparam logic [7:0] PFX_2BYTE  = 8'h0F;

    localparam logic [2:0] SEG_ES   = 3'd0;
    localparam logic [2:0] SEG_CS   = 3'd1;
    localparam logic [2:0] SEG_SS   = 3'd2;
    localparam logic [2:0] SEG_DS   = 3'd3;
    localparam logic [2:0] SEG_FS   = 3'd4;
    localparam logic [2:0] SEG_GS   = 3'd5;
    localparam logic [2:0] SEG_NONE = 3'd7;

    localparam logic [1:0] REP_NONE = 2'd0;
    localparam logic [1:0] REP_NE   = 2'd1;
    localparam logic [1:0] REP_E    = 2'd2;

    localparam int MAX_LEN = 15;

    typedef enum logic {
        SCAN  = 1'b0,
        FAULT = 1'b1
    } state_t;

    // Layout of micro_prefix: {2byte, lock, rep[1:0], seg[2:0], opsize32, addrsize32}
    function automatic logic [8:0] pack_prefix(input logic two_byte, input logic lock,
                                               input logic [1:0] rep, input logic [2:0] seg,
                                               input logic op32, input logic ad32);
        return {two_byte, lock, rep, seg, op32, ad32};
    endfunction

endpackage

// File: rtl/decode_prefix_classify.sv
// Combinational classification of one instruction byte into x86 prefix groups.
module decode_prefix_classify
    import decode_pkg::*;
(
    input  logic       [7:0] data,
    input  logic             cs_default_32bit,
    output logic             is_prefix,
    output logic             is_lock,
    output logic             is_rep,
    output logic       [1:0] rep_val,
    output logic             is_seg,
    output logic       [2:0] seg_val,
    output logic             is_opsize,
    output logic             is_addrsize,
    output logic             size_val,
    output logic             is_two_byte
);

    always_comb begin
        is_lock     = 1'b0;
        is_rep      = 1'b0;
        rep_val     = REP_NONE;
        is_seg      = 1'b0;
        seg_val     = SEG_NONE;
        is_opsize   = 1'b0;
        is_addrsize = 1'b0;
        is_two_byte = 1'b0;
        case (data)
            PFX_LOCK:   is_lock = 1'b1;
            PFX_REPNE:  begin is_rep = 1'b1; rep_val = REP_NE; end
            PFX_REP:    begin is_rep = 1'b1; rep_val = REP_E;  end
            PFX_ES:     begin is_seg = 1'b1; seg_val = SEG_ES; end
            PFX_CS:     begin is_seg = 1'b1; seg_val = SEG_CS; end
            PFX_SS:     begin is_seg = 1'b1; seg_val = SEG_SS; end
            PFX_DS:     begin is_seg = 1'b1; seg_val = SEG_DS; end
            PFX_FS:     begin is_seg = 1'b1; seg_val = SEG_FS; end
            PFX_GS:     begin is_seg = 1'b1; seg_val = SEG_GS; end
            PFX_OPSIZE: is_opsize = 1'b1;
            PFX_ADSIZE: is_addrsize = 1'b1;
            PFX_2BYTE:  is_two_byte = 1'b1;
            default:    ;
        endcase
        is_prefix = is_lock | is_rep | is_seg | is_opsize | is_addrsize | is_two_byte;
    end

    // Size-override prefixes select the non-default size of the current code segment.
    assign size_val = ~cs_default_32bit;

endmodule

// File: rtl/decode_prefix_sequencer.sv
// ao486 decode-stage sequencer: absorbs prefix bytes one per cycle, enforces the
// instruction length limit and loads completed instructions into the micro output register.
module decode_prefix_sequencer #(
    parameter int MAX_LEN = decode_pkg::MAX_LEN
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pr_reset,
    input  logic        cs_default_32bit,
    input  logic [3:0]  fetch_valid,
    input  logic [63:0] fetch,
    output logic [3:0]  dec_acceptable,
    input  logic [3:0]  consume_len,
    input  logic        dec_exception_ud,
    input  logic [6:0]  dec_cmd,
    input  logic [3:0]  dec_cmdex,
    input  logic        dec_is_8bit,
    input  logic        dec_is_complex,
    output logic        dec_prefix_group_1_lock,
    output logic [1:0]  dec_prefix_group_1_rep,
    output logic [2:0]  dec_prefix_group_2_seg,
    output logic        dec_prefix_2byte,
    output logic        dec_operand_32bit,
    output logic        dec_address_32bit,
    output logic        micro_valid,
    input  logic        micro_busy,
    output logic [6:0]  micro_cmd,
    output logic [3:0]  micro_cmdex,
    output logic        micro_is_8bit,
    output logic        micro_is_complex,
    output logic [8:0]  micro_prefix,
    output logic [3:0]  micro_len,
    output logic        micro_exception_ud,
    output logic        micro_exception_len
);
    import decode_pkg::*;

    state_t     state;
    logic [3:0] prefix_count;
    logic       lock, two_byte, op_set, op_val, ad_set, ad_val;
    logic [1:0] rep;
    logic [2:0] seg;

    logic       c_is_prefix, c_is_lock, c_is_rep, c_is_seg, c_is_opsize, c_is_addrsize;
    logic       c_size_val, c_is_two_byte;
    logic [1:0] c_rep_val;
    logic [2:0] c_seg_val;

    decode_prefix_classify u_classify (
        .data             (fetch[7:0]),
        .cs_default_32bit (cs_default_32bit),
        .is_prefix        (c_is_prefix),
        .is_lock          (c_is_lock),
        .is_rep           (c_is_rep),
        .rep_val          (c_rep_val),
        .is_seg           (c_is_seg),
        .seg_val          (c_seg_val),
        .is_opsize        (c_is_opsize),
        .is_addrsize      (c_is_addrsize),
        .size_val         (c_size_val),
        .is_two_byte      (c_is_two_byte)
    );

    logic       have_byte, prefix_hit, out_free, pfx_limit, len_err, opcode_ready;
    logic       scan_ok, take_prefix, pfx_fault, complete, load;
    logic [3:0] count_next;
    logic [4:0] sum;

    assign have_byte    = (fetch_valid != 4'd0);
    // A 0F after an earlier 0F is the second opcode byte, not another prefix.
    assign prefix_hit   = have_byte && c_is_prefix && !(c_is_two_byte && two_byte);
    assign out_free     = !micro_valid || !micro_busy;
    assign count_next   = prefix_count + 4'd1;
    assign pfx_limit    = (count_next == 4'(MAX_LEN));
    assign sum          = {1'b0, prefix_count} + {1'b0, consume_len};
    assign len_err      = (sum > 5'(MAX_LEN));
    assign opcode_ready = have_byte && !prefix_hit && ((consume_len != 4'd0) || dec_exception_ud);
    assign scan_ok      = rst_n && !pr_reset && (state == SCAN);
    // The limit-reaching prefix produces an output entry, so it waits for a free register.
    assign take_prefix  = scan_ok && prefix_hit && (!pfx_limit || out_free);
    assign pfx_fault    = take_prefix && pfx_limit;
    assign complete     = scan_ok && opcode_ready && out_free;
    assign load         = pfx_fault || complete;

    always_comb begin
        dec_acceptable = 4'd0;
        if (take_prefix)
            dec_acceptable = 4'd1;
        else if (complete && !len_err && !dec_exception_ud)
            dec_acceptable = consume_len;
    end

    assign dec_prefix_group_1_lock = lock;
    assign dec_prefix_group_1_rep  = rep;
    assign dec_prefix_group_2_seg  = seg;
    assign dec_prefix_2byte        = two_byte;
    assign dec_operand_32bit       = op_set ? op_val : cs_default_32bit;
    assign dec_address_32bit       = ad_set ? ad_val : cs_default_32bit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= SCAN;
            prefix_count <= 4'd0;
            lock         <= 1'b0;
            rep          <= REP_NONE;
            seg          <= SEG_NONE;
            two_byte     <= 1'b0;
            op_set       <= 1'b0;
            op_val       <= 1'b0;
            ad_set       <= 1'b0;
            ad_val       <= 1'b0;
        end else if (pr_reset) begin
            state        <= SCAN;
            prefix_count <= 4'd0;
            lock         <= 1'b0;
            rep          <= REP_NONE;
            seg          <= SEG_NONE;
            two_byte     <= 1'b0;
            op_set       <= 1'b0;
            op_val       <= 1'b0;
            ad_set       <= 1'b0;
            ad_val       <= 1'b0;
        end else begin
            if (take_prefix) begin
                prefix_count <= count_next;
                if (c_is_lock)     lock     <= 1'b1;
                if (c_is_rep)      rep      <= c_rep_val;
                if (c_is_seg)      seg      <= c_seg_val;
                if (c_is_two_byte) two_byte <= 1'b1;
                if (c_is_opsize)   begin op_set <= 1'b1; op_val <= c_size_val; end
                if (c_is_addrsize) begin ad_set <= 1'b1; ad_val <= c_size_val; end
            end
            if (load) begin
                prefix_count <= 4'd0;
                lock         <= 1'b0;
                rep          <= REP_NONE;
                seg          <= SEG_NONE;
                two_byte     <= 1'b0;
                op_set       <= 1'b0;
                ad_set       <= 1'b0;
            end
            if (pfx_fault || (complete && (len_err || dec_exception_ud)))
                state <= FAULT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || pr_reset) begin
            micro_valid         <= 1'b0;
            micro_cmd           <= 7'd0;
            micro_cmdex         <= 4'd0;
            micro_is_8bit       <= 1'b0;
            micro_is_complex    <= 1'b0;
            micro_prefix        <= 9'd0;
            micro_len           <= 4'd0;
            micro_exception_ud  <= 1'b0;
            micro_exception_len <= 1'b0;
        end else if (load) begin
            micro_valid         <= 1'b1;
            micro_cmd           <= pfx_fault ? 7'd0 : dec_cmd;
            micro_cmdex         <= pfx_fault ? 4'd0 : dec_cmdex;
            micro_is_8bit       <= !pfx_fault && dec_is_8bit;
            micro_is_complex    <= !pfx_fault && dec_is_complex;
            micro_prefix        <= pack_prefix(two_byte, lock, rep, seg,
                                               dec_operand_32bit, dec_address_32bit);
            micro_exception_len <= pfx_fault || len_err;
            micro_exception_ud  <= !pfx_fault && !len_err && dec_exception_ud;
            if (pfx_fault || len_err)
                micro_len <= 4'(MAX_LEN);
            else if (dec_exception_ud)
                micro_len <= prefix_count;
            else
                micro_len <= sum[3:0];
        end else if (!micro_busy) begin
            micro_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_prefix_sequencer.sv
// Directed bench for decode_prefix_sequencer: a behavioural instruction-level model
// checked every cycle, plus hand-computed expectations for the key scenarios.
module tb_decode_prefix_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pr_reset = 1'b0;
    logic        cs_default_32bit = 1'b0;
    logic [3:0]  fetch_valid = 4'd0;
    logic [63:0] fetch = 64'd0;
    logic [3:0]  dec_acceptable;
    logic [3:0]  consume_len = 4'd0;
    logic        dec_exception_ud = 1'b0;
    logic [6:0]  dec_cmd = 7'd0;
    logic [3:0]  dec_cmdex = 4'd0;
    logic        dec_is_8bit = 1'b0;
    logic        dec_is_complex = 1'b0;
    logic        dec_prefix_group_1_lock;
    logic [1:0]  dec_prefix_group_1_rep;
    logic [2:0]  dec_prefix_group_2_seg;
    logic        dec_prefix_2byte;
    logic        dec_operand_32bit;
    logic        dec_address_32bit;
    logic        micro_valid;
    logic        micro_busy = 1'b0;
    logic [6:0]  micro_cmd;
    logic [3:0]  micro_cmdex;
    logic        micro_is_8bit;
    logic        micro_is_complex;
    logic [8:0]  micro_prefix;
    logic [3:0]  micro_len;
    logic        micro_exception_ud;
    logic        micro_exception_len;

    decode_prefix_sequencer #(.MAX_LEN(15)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .pr_reset                (pr_reset),
        .cs_default_32bit        (cs_default_32bit),
        .fetch_valid             (fetch_valid),
        .fetch                   (fetch),
        .dec_acceptable          (dec_acceptable),
        .consume_len             (consume_len),
        .dec_exception_ud        (dec_exception_ud),
        .dec_cmd                 (dec_cmd),
        .dec_cmdex               (dec_cmdex),
        .dec_is_8bit             (dec_is_8bit),
        .dec_is_complex          (dec_is_complex),
        .dec_prefix_group_1_lock (dec_prefix_group_1_lock),
        .dec_prefix_group_1_rep  (dec_prefix_group_1_rep),
        .dec_prefix_group_2_seg  (dec_prefix_group_2_seg),
        .dec_prefix_2byte        (dec_prefix_2byte),
        .dec_operand_32bit       (dec_operand_32bit),
        .dec_address_32bit       (dec_address_32bit),
        .micro_valid             (micro_valid),
        .micro_busy              (micro_busy),
        .micro_cmd               (micro_cmd),
        .micro_cmdex             (micro_cmdex),
        .micro_is_8bit           (micro_is_8bit),
        .micro_is_complex        (micro_is_complex),
        .micro_prefix            (micro_prefix),
        .micro_len               (micro_len),
        .micro_exception_ud      (micro_exception_ud),
        .micro_exception_len     (micro_exception_len)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_fault, m_cnt, m_lock, m_rep, m_seg, m_two, m_op, m_ad;  // m_op/m_ad: -1 = default
    int m_mv, m_cmd, m_cmdex, m_8, m_cx, m_pfx, m_len, m_eud, m_elen;

    function automatic void model_clear_prefix();
        m_cnt = 0; m_lock = 0; m_rep = 0; m_seg = 7; m_two = 0; m_op = -1; m_ad = -1;
    endfunction

    function automatic void model_reset();
        model_clear_prefix();
        m_fault = 0; m_mv = 0; m_cmd = 0; m_cmdex = 0; m_8 = 0; m_cx = 0;
        m_pfx = 0; m_len = 0; m_eud = 0; m_elen = 0;
    endfunction

    function automatic int op32();
        return (m_op < 0) ? int'(cs_default_32bit) : m_op;
    endfunction

    function automatic int ad32();
        return (m_ad < 0) ? int'(cs_default_32bit) : m_ad;
    endfunction

    function automatic bit is_pfx(input int b);
        if (b == 8'h0F) return (m_two == 0);
        return b inside {8'hF0, 8'hF2, 8'hF3, 8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65, 8'h66, 8'h67};
    endfunction

    // ev: 0 idle/stall, 1 prefix, 2 prefix hits limit, 3 good completion, 4 UD, 5 length error
    function automatic void decide(output int acc, output int ev);
        int b;
        bit has, free;
        b = int'(fetch[7:0]);
        has = (fetch_valid != 0);
        free = (m_mv == 0) || !micro_busy;
        acc = 0; ev = 0;
        if (!rst_n || pr_reset || m_fault != 0) return;
        if (has && is_pfx(b)) begin
            if (m_cnt + 1 == 15) begin
                if (free) begin acc = 1; ev = 2; end
            end else begin
                acc = 1; ev = 1;
            end
        end else if (has && (consume_len != 0 || dec_exception_ud) && free) begin
            if (m_cnt + int'(consume_len) > 15) ev = 5;
            else if (dec_exception_ud) ev = 4;
            else begin acc = int'(consume_len); ev = 3; end
        end
    endfunction

    function automatic void model_clock();
        int acc, ev, b;
        if (pr_reset) begin model_reset(); return; end
        decide(acc, ev);
        b = int'(fetch[7:0]);
        if (m_mv != 0 && !micro_busy) m_mv = 0;
        if (ev == 1) begin
            m_cnt++;
            case (b)
                8'hF0: m_lock = 1;
                8'hF2: m_rep = 1;
                8'hF3: m_rep = 2;
                8'h26: m_seg = 0;
                8'h2E: m_seg = 1;
                8'h36: m_seg = 2;
                8'h3E: m_seg = 3;
                8'h64: m_seg = 4;
                8'h65: m_seg = 5;
                8'h66: m_op = cs_default_32bit ? 0 : 1;
                8'h67: m_ad = cs_default_32bit ? 0 : 1;
                8'h0F: m_two = 1;
                default: ;
            endcase
        end else if (ev >= 2) begin
            m_mv = 1;
            m_pfx = (m_two << 8) | (m_lock << 7) | (m_rep << 5) | (m_seg << 2) | (op32() << 1) | ad32();
            if (ev == 2) begin
                m_cmd = 0; m_cmdex = 0; m_8 = 0; m_cx = 0;
            end else begin
                m_cmd = int'(dec_cmd); m_cmdex = int'(dec_cmdex);
                m_8 = int'(dec_is_8bit); m_cx = int'(dec_is_complex);
            end
            m_elen = (ev == 2 || ev == 5) ? 1 : 0;
            m_eud  = (ev == 4) ? 1 : 0;
            m_len  = (ev == 3) ? m_cnt + int'(consume_len) : (ev == 4) ? m_cnt : 15;
            if (ev != 3) m_fault = 1;
            model_clear_prefix();
        end
    endfunction

    initial begin
        int acc, ev;
        model_reset();
        forever begin
            @(negedge clk);
            if (!rst_n) model_reset();
            decide(acc, ev);
            check("dec_acceptable", dec_acceptable, acc);
            check("micro_valid", micro_valid, m_mv);
            check("pfx_lock", dec_prefix_group_1_lock, m_lock);
            check("pfx_rep", dec_prefix_group_1_rep, m_rep);
            check("pfx_seg", dec_prefix_group_2_seg, m_seg);
            check("pfx_2byte", dec_prefix_2byte, m_two);
            check("operand_32bit", dec_operand_32bit, op32());
            check("address_32bit", dec_address_32bit, ad32());
            if (m_mv != 0) begin
                check("micro_cmd", micro_cmd, m_cmd);
                check("micro_cmdex", micro_cmdex, m_cmdex);
                check("micro_is_8bit", micro_is_8bit, m_8);
                check("micro_is_complex", micro_is_complex, m_cx);
                check("micro_prefix", micro_prefix, m_pfx);
                check("micro_len", micro_len, m_len);
                check("micro_exception_ud", micro_exception_ud, m_eud);
                check("micro_exception_len", micro_exception_len, m_elen);
            end
            @(posedge clk);
            if (rst_n) model_clock();
        end
    end

    // ---------------- directed stimulus ----------------
    int last_acc;

    task automatic step(input int fv, input int b, input int cl, input bit ud);
        fetch_valid      = 4'(fv);
        fetch            = {56'h0, 8'(b)};
        consume_len      = 4'(cl);
        dec_exception_ud = ud;
        dec_cmd          = 7'(b);
        dec_cmdex        = 4'(cl + 1);
        dec_is_8bit      = 1'(b & 1);
        dec_is_complex   = 1'((b >> 1) & 1);
        @(negedge clk); #1;
        last_acc = int'(dec_acceptable);
        @(posedge clk); #1;
    endtask

    task automatic flush();
        pr_reset = 1'b1;
        step(0, 0, 0, 1'b0);
        pr_reset = 1'b0;
    endtask

    initial begin
        int accs[4];
        int seq[4];
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_valid", micro_valid, 0);
        check("reset_seg", dec_prefix_group_2_seg, 7);

        // 66 F3 2E + opcode, cs D=0
        seq = '{8'h66, 8'hF3, 8'h2E, 8'h8B};
        for (int i = 0; i < 4; i++) begin
            step(8, seq[i], (i == 3) ? 2 : 0, 1'b0);
            accs[i] = last_acc;
        end
        check("A_acc0", accs[0], 1);
        check("A_acc1", accs[1], 1);
        check("A_acc2", accs[2], 1);
        check("A_acc3", accs[3], 2);
        check("A_len", micro_len, 5);
        check("A_seg", micro_prefix[4:2], 1);
        check("A_rep", micro_prefix[6:5], 2);
        check("A_op32", micro_prefix[1], 1);
        check("A_seg_default", dec_prefix_group_2_seg, 7);
        check("A_op_default", dec_operand_32bit, 0);

        // output held while busy, prefixes still consumed
        micro_busy = 1'b1;
        step(8, 8'h90, 1, 1'b0);
        check("B_stall_acc", last_acc, 0);
        check("B_held_len", micro_len, 5);
        step(8, 8'h3E, 0, 1'b0);
        check("B_pfx_while_busy", last_acc, 1);
        micro_busy = 1'b0;
        step(8, 8'h90, 1, 1'b0);
        check("B_drain_acc", last_acc, 1);
        check("B_valid", micro_valid, 1);
        check("B_len", micro_len, 2);
        step(0, 0, 0, 1'b0);
        check("B_valid_fall", micro_valid, 0);

        // UD after two prefixes
        step(8, 8'hF0, 0, 1'b0);
        step(8, 8'h65, 0, 1'b0);
        step(8, 8'hFF, 0, 1'b1);
        check("C_acc", last_acc, 0);
        check("C_ud", micro_exception_ud, 1);
        check("C_len", micro_len, 2);
        step(8, 8'h26, 0, 1'b0);
        check("C_fault_acc", last_acc, 0);
        flush();
        check("C_flush_valid", micro_valid, 0);
        step(8, 8'h26, 0, 1'b0);
        check("C_scan_acc", last_acc, 1);
        flush();

        // 15 segment prefixes
        for (int i = 0; i < 15; i++) begin
            step(8, 8'h26, 0, 1'b0);
            check("D_acc", last_acc, 1);
        end
        check("D_elen", micro_exception_len, 1);
        check("D_len", micro_len, 15);
        for (int i = 0; i < 3; i++) begin
            step(8, 8'h26, 0, 1'b0);
            check("D_fault_acc", last_acc, 0);
        end
        flush();

        // 13 prefixes + 3-byte opcode overflows
        for (int i = 0; i < 13; i++) step(8, 8'h2E, 0, 1'b0);
        step(8, 8'hB8, 3, 1'b0);
        check("E_acc", last_acc, 0);
        check("E_elen", micro_exception_len, 1);
        check("E_len", micro_len, 15);
        flush();

        // rep last-wins, 0F 0F, opsize override with D=1
        cs_default_32bit = 1'b1;
        step(8, 8'hF2, 0, 1'b0);
        step(8, 8'hF3, 0, 1'b0);
        step(8, 8'h0F, 0, 1'b0);
        check("F_2byte", dec_prefix_2byte, 1);
        check("F_op_default", dec_operand_32bit, 1);
        step(8, 8'h66, 0, 1'b0);
        check("F_op_override", dec_operand_32bit, 0);
        step(8, 8'h0F, 2, 1'b0);
        check("F_acc", last_acc, 2);
        check("F_len", micro_len, 6);
        check("F_prefix", micro_prefix, 9'h15D);
        cs_default_32bit = 1'b0;

        // flush collides with a completion
        step(8, 8'hF0, 0, 1'b0);
        pr_reset = 1'b1;
        step(8, 8'h90, 1, 1'b0);
        pr_reset = 1'b0;
        check("G_acc", last_acc, 0);
        check("G_valid", micro_valid, 0);
        check("G_lock", dec_prefix_group_1_lock, 0);

        // empty window
        step(0, 8'h66, 0, 1'b0);
        check("H_acc", last_acc, 0);

        // asynchronous reset mid-stream
        micro_busy = 1'b1;
        step(8, 8'h90, 1, 1'b0);
        check("I_valid_before", micro_valid, 1);
        step(8, 8'h26, 0, 1'b0);
        rst_n = 1'b0;
        #2;
        check("I_valid", micro_valid, 0);
        check("I_seg", dec_prefix_group_2_seg, 7);
        check("I_rep", dec_prefix_group_1_rep, 0);
        check("I_acc", dec_acceptable, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        micro_busy = 1'b0;
        step(0, 0, 0, 1'b0);
        step(0, 0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_prefix_sequencer.md
# decode_prefix_sequencer

Sequences the ao486 decode stage. Each cycle it consumes one prefix byte from the fetch window, or hands the opcode bytes to the decode command logic. It accumulates the prefix state and enforces the 15-byte instruction limit. Completed instructions, including any decode exceptions, are loaded into a one-entry output register that feeds the micro stage through a valid/busy handshake.

## Interface
Parameters:
- MAX_LEN, 15, maximum architectural instruction length in bytes.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pr_reset  in  1  synchronous pipeline flush; overrides every other input.
- cs_default_32bit  in  1  code segment D bit; sets the default operand/address size.
- fetch_valid  in  4  valid bytes in the window, 0..8.
- fetch  in  64  byte window; fetch[7:0] is the oldest byte.
- dec_acceptable  out  4  bytes retired from the window this cycle (combinational).
- consume_len  in  4  opcode+operand length reported by the decode command logic; 0 = not yet decodable.
- dec_exception_ud  in  1  invalid opcode flagged by the decode command logic.
- dec_cmd  in  7, dec_cmdex  in  4, dec_is_8bit  in  1, dec_is_complex  in  1  decoded command fields.
- dec_prefix_group_1_lock  out  1, dec_prefix_group_1_rep  out  2, dec_prefix_group_2_seg  out  3, dec_prefix_2byte  out  1, dec_operand_32bit  out  1, dec_address_32bit  out  1  current prefix state, driven to the decode logic.
- micro_valid  out  1  output register full.
- micro_busy  in  1  micro stage cannot accept.
- micro_cmd  out  7, micro_cmdex  out  4, micro_is_8bit  out  1, micro_is_complex  out  1, micro_prefix  out  9 (lock, rep, seg, opsize32, addrsize32), micro_len  out  4, micro_exception_ud  out  1, micro_exception_len  out  1.

## Operation
- States: SCAN and FAULT.
- Reset (rst_n=0) or pr_reset:
  - state=SCAN, micro_valid=0, prefix_count=0.
  - Prefix state returns to defaults: lock=0, rep=0, seg=7 (none), 2byte=0, opsize/addrsize=cs_default_32bit.
  - All micro_* outputs are 0.
- Byte classification of fetch[7:0], applied only when fetch_valid≥1:
  - F0: lock=1.
  - F2: rep=1.
  - F3: rep=2.
  - 26/2E/36/3E/64/65: seg=0/1/2/3/4/5.
  - 66: opsize=!cs_default_32bit.
  - 67: addrsize=!cs_default_32bit.
  - 0F: 2byte=1, only when 2byte is 0. A second 0F is an opcode.
  - When the same group repeats, the last prefix wins.
- SCAN, prefix byte at fetch[7:0]:
  - dec_acceptable=1 and prefix_count+1.
  - If the increment reaches MAX_LEN: load output with micro_exception_len=1, micro_len=MAX_LEN, and go to FAULT.
- SCAN, non-prefix byte, with consume_len≠0 or dec_exception_ud=1, and the output register free:
  - "Free" means micro_valid=0, or micro_busy=0 (the register drains in the same cycle).
  - The decode fields and prefix state are loaded into the output register.
  - micro_len = prefix_count + consume_len.
  - dec_acceptable = consume_len.
  - Prefix state and prefix_count clear to defaults on the same edge.
- Length check on completion: if prefix_count+consume_len > MAX_LEN, set micro_exception_len=1, dec_acceptable=0, and go to FAULT.
- UD on completion: dec_exception_ud=1 sets micro_exception_ud=1, micro_len=prefix_count, dec_acceptable=0, and goes to FAULT. Length exception takes priority over UD.
- Output register not free: dec_acceptable=0 for the opcode; prefix consumption continues.
- FAULT: dec_acceptable=0 until pr_reset. The output register still drains normally.
- Widths: prefix_count is 4 bits and never exceeds MAX_LEN. The sum is computed in 5 bits.

## Timing
- Prefix throughput: 1 byte/cycle. Instruction completion: 1 per cycle when micro_busy=0.
- Latency: micro_valid rises on the edge after the completing cycle.
- dec_acceptable is combinational from state, the fetch inputs, consume_len, micro_valid and micro_busy.
- Output register: it holds while micro_valid=1 and micro_busy=1. micro_valid falls on the edge after micro_busy=0 unless a new instruction loads.
- pr_reset in the same cycle as a completion: the flush wins; nothing loads and dec_acceptable=0.
- rst_n asserted mid-operation clears state immediately, with no dependence on the clock.

## Structure
- Shared package decode_pkg:
  - prefix byte constants;
  - SEG_ES..SEG_GS and SEG_NONE=3'd7;
  - REP_NONE/REP_NE/REP_E;
  - state enum SCAN/FAULT;
  - MAX_LEN.
- Sub-module decode_prefix_classify: combinational; takes a byte plus cs_default_32bit and returns is_prefix plus the group/value fields.

## Test plan
- Reset: rst_n low mid-stream → micro_valid=0, seg=7, rep=0, dec_acceptable=0.
- 66 F3 2E + opcode with consume_len=2, cs_default_32bit=0:
  - dec_acceptable=1,1,1,2;
  - micro_len=5, seg=1, rep=2, opsize32=1;
  - prefix state at defaults the next cycle.
- 15 consecutive 26 bytes → on the 15th, micro_exception_len=1 and micro_len=15; FAULT holds dec_acceptable=0 until pr_reset.
- micro_busy=1 with the output full while the next opcode is ready → dec_acceptable=0 and output held. With micro_busy=0, the new instruction loads in the same cycle and micro_valid stays 1.
- Two prefixes then dec_exception_ud=1 → micro_exception_ud=1, micro_len=2, FAULT. pr_reset → SCAN and micro_valid=0 the next cycle.
